morra_cinese_n: RTL and testbench
=================================

# morra_cinese_n

Parametrised rock-paper-scissors match controller: the successor of the fixed 3-move `MorraCinese` block. It generalises the game to any odd number of cyclic moves and a configurable match length and early-win margin. It also exposes live scores and remaining rounds. It sits between the two player-input registers and the display/score logic, one round evaluated per clock.

## Interface
- `N_MOSSE`, 3: number of valid moves; must be odd and ≥3. Move codes are 1..N_MOSSE; code 0 is invalid.
- `W_MOSSA`, $clog2(N_MOSSE+1): width of a move code.
- `MIN_MANCHE`, 4: base number of rounds.
- `VANTAGGIO`, 2: lead that ends a match early; 0 disables early end.
- `W_CNT`, $clog2(MIN_MANCHE + 2**(2*W_MOSSA)): width of the round/score counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `INIZIA` in 1: start or restart a match; sampled each cycle.
- `PRIMO` in W_MOSSA: player 1 move; during INIZIA, high half of the length config.
- `SECONDO` in W_MOSSA: player 2 move; during INIZIA, low half of the length config.
- `MANCHE` out 2: round result. 00 = invalid or no round, 01 = P1 wins, 10 = P2 wins, 11 = tie.
- `PARTITA` out 2: match result. 00 = running or idle, 01 = P1, 10 = P2, 11 = draw.
- `PUNTI1`, `PUNTI2` out W_CNT: round wins of each player in the current match.
- `RIMASTE` out W_CNT: valid rounds still to play.
- `ATTIVA` out 1: a match is in progress.

## Operation
- FSM states: IDLE and GIOCO.
- Reset, or IDLE without INIZIA: every output is 0.
- INIZIA=1, from any state: latch `max = MIN_MANCHE + {PRIMO,SECONDO}`, clear both scores, clear the last-winner memory, set RIMASTE=max, go to GIOCO. MANCHE and PARTITA are 00 that cycle. INIZIA always takes priority, including a restart mid-match.
- GIOCO with INIZIA=0: each cycle is one round attempt. A round is invalid, giving MANCHE=00 and no counter change, if either:
  - either move is 0 or greater than N_MOSSE, or
  - the previous valid round's winner repeats the move it won with.
- Valid round: compute `d = (PRIMO - SECONDO) mod N_MOSSE`.
  - d=0 → tie (11).
  - 1 ≤ d ≤ (N_MOSSE-1)/2 → P1 wins (01).
  - otherwise → P2 wins (10).
  - The winner's score increments. The last winner and its move are recorded; a tie clears that record. RIMASTE decrements.
- End of match, evaluated on post-update values: RIMASTE reaches 0, or VANTAGGIO≠0 with |PUNTI1−PUNTI2| ≥ VANTAGGIO and played rounds ≥ MIN_MANCHE.
  - PARTITA = the leader, or 11 if scores are equal, for exactly one cycle together with the final MANCHE.
  - Then go to IDLE. PUNTI and RIMASTE hold until the next INIZIA or `rst`.
- IDLE: moves are ignored and MANCHE=00.

## Timing
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k, so latency is 1 cycle.
- `rst` high at an edge overrides INIZIA and all moves. Outputs are 0 after that edge, and the match is lost even if it was mid-play.
- The modulo subtraction uses W_MOSSA+1 bits with one conditional add of N_MOSSE; no divider.
- Score saturation is not needed: the counters can never exceed max.
- ATTIVA deasserts on the edge after the one where PARTITA≠00.

## Structure
- Package `morra_pkg` holds:
  - the MANCHE/PARTITA encodings as localparams: `ESITO_NULLO`, `ESITO_G1`, `ESITO_G2`, `ESITO_PARI`;
  - the state enum `stato_t`.
- Sub-module `morra_giudice`: combinational round judge, parametrised by N_MOSSE. Inputs are the two moves and the last-winner record; outputs are `valida` and `esito`.
- The top module holds the FSM, counters and output registers.

## Test plan
- N=3, INIZIA with 00/00 (max 4); P1 wins rounds 01vs11, 11vs10, 10vs01 → MANCHE 01 three times. At 3-0 with 3 played, below MIN_MANCHE, the match continues. A fourth win 01vs11 → PARTITA=01, PUNTI1=4.
- Repeat rule: P2 wins 01vs10, then P2 plays 10 again against P1 01 → MANCHE=00, RIMASTE unchanged. Next P1 01 vs P2 11 → valid, P1 wins.
- INIZIA 00/01 (max 5); rounds 0-1, invalid 00/00, tie, tie, 1-1, tie → after 5 valid rounds PARTITA=11, ATTIVA falls next cycle.
- Early end, VANTAGGIO=2, max 8: P2 wins 4 straight → PARTITA=10 on the 4th round, RIMASTE=4.
- N_MOSSE=5: check all 25 valid move pairs and both invalid codes 0 and 7 against the d-rule. Exactly one result per pair; tie only on the diagonal.
- `rst` mid-match, and INIZIA mid-match with config 01/00 → all counters reset. RIMASTE=8 after INIZIA; all outputs 0 after `rst`.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings and state type for the morra_cinese_n match controller.
package morra_pkg;

  // Round (MANCHE) and match (PARTITA) result codes.
  localparam logic [1:0] ESITO_NULLO = 2'b00;
  localparam logic [1:0] ESITO_G1    = 2'b01;
  localparam logic [1:0] ESITO_G2    = 2'b10;
  localparam logic [1:0] ESITO_PARI  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    GIOCO = 1'b1
  } stato_t;

endpackage

// File: rtl/morra_giudice.sv
// Combinational round judge for an odd number of cyclic moves.
// A round is valid when both codes are in 1..N_MOSSE and the previous
// winner does not repeat its winning move; the winner follows the
// cyclic distance d = (primo - secondo) mod N_MOSSE.
module morra_giudice
  import morra_pkg::*;
#(
  parameter int N_MOSSE = 3,
  parameter int W_MOSSA = $clog2(N_MOSSE + 1)
) (
  input  logic [W_MOSSA-1:0] primo,
  input  logic [W_MOSSA-1:0] secondo,
  input  logic               ult_valido,
  input  logic               ult_g2,
  input  logic [W_MOSSA-1:0] ult_mossa,
  output logic               valida,
  output logic [1:0]         esito
);

  localparam logic [W_MOSSA:0] N_EXT = (W_MOSSA + 1)'(N_MOSSE);
  localparam logic [W_MOSSA:0] META  = (W_MOSSA + 1)'((N_MOSSE - 1) / 2);

  logic [W_MOSSA:0] diff;
  logic [W_MOSSA:0] d;
  logic             codici_ok;
  logic             ripetuta;

  // Validity check, modular distance (one conditional add) and verdict.
  always_comb begin
    codici_ok = (primo != '0) && ({1'b0, primo} <= N_EXT) &&
                (secondo != '0) && ({1'b0, secondo} <= N_EXT);
    ripetuta  = ult_valido && (ult_g2 ? (secondo == ult_mossa) : (primo == ult_mossa));
    valida    = codici_ok && !ripetuta;
    // Both operands are below N_MOSSE+1, so the extra bit acts as a sign.
    diff      = {1'b0, primo} - {1'b0, secondo};
    d         = diff[W_MOSSA] ? (diff + N_EXT) : diff;
    esito     = ESITO_NULLO;
    if (valida) begin
      if (d == '0) begin
        esito = ESITO_PARI;
      end else if (d <= META) begin
        esito = ESITO_G1;
      end else begin
        esito = ESITO_G2;
      end
    end
  end

endmodule

// File: rtl/morra_cinese_n.sv
// Parametrised rock-paper-scissors match controller: FSM, score and
// round counters, early-win detection and registered outputs.
module morra_cinese_n
  import morra_pkg::*;
#(
  parameter int N_MOSSE    = 3,
  parameter int W_MOSSA    = $clog2(N_MOSSE + 1),
  parameter int MIN_MANCHE = 4,
  parameter int VANTAGGIO  = 2,
  parameter int W_CNT      = $clog2(MIN_MANCHE + 2**(2 * W_MOSSA))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INIZIA,
  input  logic [W_MOSSA-1:0] PRIMO,
  input  logic [W_MOSSA-1:0] SECONDO,
  output logic [1:0]         MANCHE,
  output logic [1:0]         PARTITA,
  output logic [W_CNT-1:0]   PUNTI1,
  output logic [W_CNT-1:0]   PUNTI2,
  output logic [W_CNT-1:0]   RIMASTE,
  output logic               ATTIVA
);

  localparam logic [W_CNT-1:0] MIN_C  = W_CNT'(MIN_MANCHE);
  localparam logic [W_CNT-1:0] VANT_C = W_CNT'(VANTAGGIO);

  stato_t             stato_q, stato_d;
  logic [1:0]         manche_q, manche_d;
  logic [1:0]         partita_q, partita_d;
  logic [W_CNT-1:0]   punti1_q, punti1_d;
  logic [W_CNT-1:0]   punti2_q, punti2_d;
  logic [W_CNT-1:0]   rimaste_q, rimaste_d;
  logic [W_CNT-1:0]   giocate_q, giocate_d;
  logic               attiva_q, attiva_d;
  logic               ult_valido_q, ult_valido_d;
  logic               ult_g2_q, ult_g2_d;
  logic [W_MOSSA-1:0] ult_mossa_q, ult_mossa_d;

  logic               valida;
  logic [1:0]         esito;
  logic [W_CNT-1:0]   distacco;
  logic               fine;

  morra_giudice #(
    .N_MOSSE (N_MOSSE),
    .W_MOSSA (W_MOSSA)
  ) u_giudice (
    .primo      (PRIMO),
    .secondo    (SECONDO),
    .ult_valido (ult_valido_q),
    .ult_g2     (ult_g2_q),
    .ult_mossa  (ult_mossa_q),
    .valida     (valida),
    .esito      (esito)
  );

  // Next state: restart has priority, otherwise score one valid round.
  always_comb begin
    stato_d      = stato_q;
    manche_d     = ESITO_NULLO;
    partita_d    = ESITO_NULLO;
    punti1_d     = punti1_q;
    punti2_d     = punti2_q;
    rimaste_d    = rimaste_q;
    giocate_d    = giocate_q;
    ult_valido_d = ult_valido_q;
    ult_g2_d     = ult_g2_q;
    ult_mossa_d  = ult_mossa_q;
    // ATTIVA lags the FSM by one edge so it stays up alongside PARTITA.
    attiva_d     = (stato_q == GIOCO);
    distacco     = '0;
    fine         = 1'b0;
    if (INIZIA) begin
      stato_d      = GIOCO;
      attiva_d     = 1'b1;
      rimaste_d    = MIN_C + W_CNT'({PRIMO, SECONDO});
      punti1_d     = '0;
      punti2_d     = '0;
      giocate_d    = '0;
      ult_valido_d = 1'b0;
    end else if (stato_q == GIOCO && valida) begin
      manche_d  = esito;
      rimaste_d = rimaste_q - 1'b1;
      giocate_d = giocate_q + 1'b1;
      if (esito == ESITO_G1) begin
        punti1_d     = punti1_q + 1'b1;
        ult_valido_d = 1'b1;
        ult_g2_d     = 1'b0;
        ult_mossa_d  = PRIMO;
      end else if (esito == ESITO_G2) begin
        punti2_d     = punti2_q + 1'b1;
        ult_valido_d = 1'b1;
        ult_g2_d     = 1'b1;
        ult_mossa_d  = SECONDO;
      end else begin
        ult_valido_d = 1'b0;
      end
      distacco = (punti1_d >= punti2_d) ? (punti1_d - punti2_d) : (punti2_d - punti1_d);
      fine = (rimaste_d == '0) ||
             ((VANT_C != '0) && (distacco >= VANT_C) && (giocate_d >= MIN_C));
      if (fine) begin
        stato_d = IDLE;
        if (punti1_d > punti2_d) begin
          partita_d = ESITO_G1;
        end else if (punti2_d > punti1_d) begin
          partita_d = ESITO_G2;
        end else begin
          partita_d = ESITO_PARI;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stato_q      <= IDLE;
      manche_q     <= ESITO_NULLO;
      partita_q    <= ESITO_NULLO;
      punti1_q     <= '0;
      punti2_q     <= '0;
      rimaste_q    <= '0;
      giocate_q    <= '0;
      attiva_q     <= 1'b0;
      ult_valido_q <= 1'b0;
      ult_g2_q     <= 1'b0;
      ult_mossa_q  <= '0;
    end else begin
      stato_q      <= stato_d;
      manche_q     <= manche_d;
      partita_q    <= partita_d;
      punti1_q     <= punti1_d;
      punti2_q     <= punti2_d;
      rimaste_q    <= rimaste_d;
      giocate_q    <= giocate_d;
      attiva_q     <= attiva_d;
      ult_valido_q <= ult_valido_d;
      ult_g2_q     <= ult_g2_d;
      ult_mossa_q  <= ult_mossa_d;
    end
  end

  assign MANCHE  = manche_q;
  assign PARTITA = partita_q;
  assign PUNTI1  = punti1_q;
  assign PUNTI2  = punti2_q;
  assign RIMASTE = rimaste_q;
  assign ATTIVA  = attiva_q;

endmodule

// File: tb/tb_morra_cinese_n.sv
// Directed bench for morra_cinese_n: a 3-move instance for match flow and
// a 5-move instance for the round judge table.
module tb_morra_cinese_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       ini3 = 1'b0;
  logic [1:0] p3 = '0, s3 = '0;
  logic [1:0] m3, pa3;
  logic [4:0] pu1_3, pu2_3, ri3;
  logic       at3;

  logic       ini5 = 1'b0;
  logic [2:0] p5 = '0, s5 = '0;
  logic [1:0] m5, pa5;
  logic [6:0] pu1_5, pu2_5, ri5;
  logic       at5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  morra_cinese_n #(.N_MOSSE(3), .MIN_MANCHE(4), .VANTAGGIO(2)) dut3 (
    .clk(clk), .rst(rst), .INIZIA(ini3), .PRIMO(p3), .SECONDO(s3),
    .MANCHE(m3), .PARTITA(pa3), .PUNTI1(pu1_3), .PUNTI2(pu2_3),
    .RIMASTE(ri3), .ATTIVA(at3)
  );

  morra_cinese_n #(.N_MOSSE(5), .MIN_MANCHE(4), .VANTAGGIO(2)) dut5 (
    .clk(clk), .rst(rst), .INIZIA(ini5), .PRIMO(p5), .SECONDO(s5),
    .MANCHE(m5), .PARTITA(pa5), .PUNTI1(pu1_5), .PUNTI2(pu2_5),
    .RIMASTE(ri5), .ATTIVA(at5)
  );

  task automatic step3(input logic ini, input logic [1:0] p, input logic [1:0] s);
    ini3 = ini; p3 = p; s3 = s;
    @(posedge clk); #1;
    $display("dut3 rst=%0d ini=%0d p=%0d s=%0d -> manche=%b partita=%b p1=%0d p2=%0d rim=%0d att=%0d",
             rst, ini, p, s, m3, pa3, pu1_3, pu2_3, ri3, at3);
  endtask

  task automatic step5(input logic ini, input logic [2:0] p, input logic [2:0] s);
    ini5 = ini; p5 = p; s5 = s;
    @(posedge clk); #1;
    $display("dut5 ini=%0d p=%0d s=%0d -> manche=%b rim=%0d", ini, p, s, m5, ri5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step3(1'b1, 2'd1, 2'd3);
    total++;
    if ({m3, pa3, pu1_3, pu2_3, ri3, at3} !== '0) begin
      bad++; $display("FAIL reset_dut3 got=%b exp=0", {m3, pa3, pu1_3, pu2_3, ri3, at3});
    end
    total++;
    if ({m5, pa5, pu1_5, pu2_5, ri5, at5} !== '0) begin
      bad++; $display("FAIL reset_dut5 got=%b exp=0", {m5, pa5, pu1_5, pu2_5, ri5, at5});
    end
    rst = 1'b0;
    step3(1'b0, 2'd1, 2'd3);
    total++;
    if ({m3, pa3, at3, ri3} !== '0) begin
      bad++; $display("FAIL idle_no_start got=%b exp=0", {m3, pa3, at3, ri3});
    end
  endtask

  task automatic test_p1_wins();
    int tp[4]  = '{1, 3, 2, 1};
    int ts[4]  = '{3, 2, 1, 3};
    int epa[4] = '{0, 0, 0, 1};
    int eri[4] = '{3, 2, 1, 0};
    step3(1'b1, 2'd0, 2'd0);
    total++;
    if (ri3 !== 5'd4 || at3 !== 1'b1 || m3 !== 2'b00 || pa3 !== 2'b00) begin
      bad++; $display("FAIL p1_start rim=%0d att=%0d m=%b pa=%b exp 4 1 00 00", ri3, at3, m3, pa3);
    end
    for (int i = 0; i < 4; i++) begin
      step3(1'b0, 2'(tp[i]), 2'(ts[i]));
      total++;
      if (m3 !== 2'b01 || pa3 !== 2'(epa[i]) || ri3 !== 5'(eri[i]) || pu1_3 !== 5'(i + 1) || pu2_3 !== 5'd0) begin
        bad++; $display("FAIL p1_round%0d m=%b pa=%b rim=%0d p1=%0d p2=%0d exp 01 %b %0d %0d 0",
                        i, m3, pa3, ri3, pu1_3, pu2_3, 2'(epa[i]), eri[i], i + 1);
      end
    end
    step3(1'b0, 2'd2, 2'd3);
    total++;
    if (at3 !== 1'b0 || pa3 !== 2'b00 || m3 !== 2'b00 || pu1_3 !== 5'd4 || ri3 !== 5'd0) begin
      bad++; $display("FAIL p1_after att=%0d pa=%b m=%b p1=%0d rim=%0d exp 0 00 00 4 0", at3, pa3, m3, pu1_3, ri3);
    end
  endtask

  task automatic test_repeat_rule();
    int tp[3]  = '{1, 1, 1};
    int ts[3]  = '{2, 2, 3};
    int em[3]  = '{2, 0, 1};
    int eri[3] = '{3, 3, 2};
    step3(1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step3(1'b0, 2'(tp[i]), 2'(ts[i]));
      total++;
      if (m3 !== 2'(em[i]) || ri3 !== 5'(eri[i])) begin
        bad++; $display("FAIL repeat_round%0d m=%b rim=%0d exp %b %0d", i, m3, ri3, 2'(em[i]), eri[i]);
      end
    end
    total++;
    if (pu1_3 !== 5'd1 || pu2_3 !== 5'd1) begin
      bad++; $display("FAIL repeat_scores p1=%0d p2=%0d exp 1 1", pu1_3, pu2_3);
    end
  endtask

  task automatic test_draw();
    int tp[6]  = '{1, 0, 1, 2, 2, 1};
    int ts[6]  = '{2, 0, 1, 2, 1, 1};
    int em[6]  = '{2, 0, 3, 3, 1, 3};
    int epa[6] = '{0, 0, 0, 0, 0, 3};
    int eri[6] = '{4, 4, 3, 2, 1, 0};
    step3(1'b1, 2'd0, 2'd1);
    total++;
    if (ri3 !== 5'd5 || pu1_3 !== 5'd0 || pu2_3 !== 5'd0) begin
      bad++; $display("FAIL draw_start rim=%0d p1=%0d p2=%0d exp 5 0 0", ri3, pu1_3, pu2_3);
    end
    for (int i = 0; i < 6; i++) begin
      step3(1'b0, 2'(tp[i]), 2'(ts[i]));
      total++;
      if (m3 !== 2'(em[i]) || pa3 !== 2'(epa[i]) || ri3 !== 5'(eri[i]) || at3 !== 1'b1) begin
        bad++; $display("FAIL draw_round%0d m=%b pa=%b rim=%0d att=%0d exp %b %b %0d 1",
                        i, m3, pa3, ri3, at3, 2'(em[i]), 2'(epa[i]), eri[i]);
      end
    end
    step3(1'b0, 2'd0, 2'd0);
    total++;
    if (at3 !== 1'b0 || pa3 !== 2'b00 || pu1_3 !== 5'd1 || pu2_3 !== 5'd1) begin
      bad++; $display("FAIL draw_after att=%0d pa=%b p1=%0d p2=%0d exp 0 00 1 1", at3, pa3, pu1_3, pu2_3);
    end
  endtask

  task automatic test_early_end();
    int tp[4]  = '{1, 2, 3, 1};
    int ts[4]  = '{2, 3, 1, 2};
    int epa[4] = '{0, 0, 0, 2};
    step3(1'b1, 2'd1, 2'd0);
    total++;
    if (ri3 !== 5'd8) begin
      bad++; $display("FAIL early_start rim=%0d exp 8", ri3);
    end
    for (int i = 0; i < 4; i++) begin
      step3(1'b0, 2'(tp[i]), 2'(ts[i]));
      total++;
      if (m3 !== 2'b10 || pa3 !== 2'(epa[i]) || ri3 !== 5'(7 - i) || pu2_3 !== 5'(i + 1)) begin
        bad++; $display("FAIL early_round%0d m=%b pa=%b rim=%0d p2=%0d exp 10 %b %0d %0d",
                        i, m3, pa3, ri3, pu2_3, 2'(epa[i]), 7 - i, i + 1);
      end
    end
    step3(1'b0, 2'd2, 2'd3);
    total++;
    if (at3 !== 1'b0 || m3 !== 2'b00 || ri3 !== 5'd4 || pu2_3 !== 5'd4) begin
      bad++; $display("FAIL early_after att=%0d m=%b rim=%0d p2=%0d exp 0 00 4 4", at3, m3, ri3, pu2_3);
    end
  endtask

  task automatic test_n5();
    int bp[4] = '{0, 7, 1, 1};
    int bs[4] = '{1, 1, 0, 7};
    for (int p = 1; p <= 5; p++) begin
      for (int s = 1; s <= 5; s++) begin
        int d;
        logic [1:0] exp_m;
        d = (((p - s) % 5) + 5) % 5;
        exp_m = (d == 0) ? 2'b11 : ((d <= 2) ? 2'b01 : 2'b10);
        step5(1'b1, 3'd7, 3'd7);
        step5(1'b0, 3'(p), 3'(s));
        total++;
        if (m5 !== exp_m || ri5 !== 7'd66) begin
          bad++; $display("FAIL n5_pair_%0d_%0d m=%b rim=%0d exp %b 66", p, s, m5, ri5, exp_m);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step5(1'b1, 3'd7, 3'd7);
      step5(1'b0, 3'(bp[i]), 3'(bs[i]));
      total++;
      if (m5 !== 2'b00 || ri5 !== 7'd67) begin
        bad++; $display("FAIL n5_invalid_%0d_%0d m=%b rim=%0d exp 00 67", bp[i], bs[i], m5, ri5);
      end
    end
  endtask

  task automatic test_rst_restart();
    step3(1'b1, 2'd0, 2'd0);
    step3(1'b0, 2'd1, 2'd3);
    total++;
    if (pu1_3 !== 5'd1 || ri3 !== 5'd3) begin
      bad++; $display("FAIL restart_pre p1=%0d rim=%0d exp 1 3", pu1_3, ri3);
    end
    step3(1'b1, 2'd1, 2'd0);
    total++;
    if (ri3 !== 5'd8 || pu1_3 !== 5'd0 || pu2_3 !== 5'd0 || m3 !== 2'b00 || at3 !== 1'b1) begin
      bad++; $display("FAIL restart_mid rim=%0d p1=%0d p2=%0d m=%b att=%0d exp 8 0 0 00 1", ri3, pu1_3, pu2_3, m3, at3);
    end
    step3(1'b0, 2'd1, 2'd3);
    total++;
    if (m3 !== 2'b01 || ri3 !== 5'd7) begin
      bad++; $display("FAIL restart_round m=%b rim=%0d exp 01 7", m3, ri3);
    end
    rst = 1'b1;
    step3(1'b1, 2'd3, 2'd2);
    total++;
    if ({m3, pa3, pu1_3, pu2_3, ri3, at3} !== '0) begin
      bad++; $display("FAIL rst_mid got=%b exp=0", {m3, pa3, pu1_3, pu2_3, ri3, at3});
    end
    rst = 1'b0;
    step3(1'b0, 2'd3, 2'd2);
    total++;
    if (m3 !== 2'b00 || at3 !== 1'b0 || ri3 !== 5'd0) begin
      bad++; $display("FAIL rst_after m=%b att=%0d rim=%0d exp 00 0 0", m3, at3, ri3);
    end
  endtask

  initial begin
    test_reset();
    test_p1_wins();
    test_repeat_rule();
    test_draw();
    test_early_end();
    test_n5();
    test_rst_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
